axi_wr_slave: RTL and testbench
===============================

// Module: axi_wr_slave
// PURPOSE
// - AXI write-channel responder: drives AWREADY/WREADY/BVALID/BRESP for the AW, W and B bus that the monitor tap observes.
// - Decodes one burst at a time (FIXED/INCR/WRAP) and stores beats in an internal word memory.
// - Returns one B response per burst and gives the bench a debug read port.
// PARAMETERS
// - ADDR_W   16   byte-address width
// - DATA_W   32   data width; one beat is 4 bytes
// - DEPTH    256  memory words; valid word index is 0..DEPTH-1
// PORTS
// - CLK        in   1       clock
// - RESET      in   1       asynchronous, active-low reset
// - AWADDR     in   ADDR_W  burst start byte address
// - AWLEN      in   8       beats-1
// - AWSIZE     in   3       beat size; only 3'd2 is legal
// - AWBUSRT    in   2       burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved
// - AWVALID    in   1       address valid
// - AWREADY    out  1       address ready
// - WDATA      in   DATA_W  write data
// - WLAST      in   1       master's last-beat flag
// - WVALID     in   1       data valid
// - WREADY     out  1       data ready
// - BRESP      out  2       00 OKAY, 10 SLVERR
// - BVALID     out  1       response valid
// - BREADY     in   1       response ready
// - DBG_RADDR  in   log2(DEPTH)  debug word index
// - DBG_RDATA  out  DATA_W  mem[DBG_RADDR], registered, 1-cycle latency
// BEHAVIOUR
// - Reset values: AWREADY=0, WREADY=0, BVALID=0, BRESP=00, DBG_RDATA=0, FSM=IDLE, beat count=0. Memory is not reset.
// - Outputs are registered. AWREADY rises on the first clock edge after RESET deasserts.
// - FSM IDLE (AWREADY=1):
//   - On AWVALID&AWREADY: latch AW fields, clear the error flag, go to DATA.
//   - WREADY rises on the next cycle. A W beat presented earlier waits.
// - FSM DATA (WREADY=1):
//   - Each WVALID&WREADY writes one beat and increments the beat count.
//   - The beat where count==AWLEN ends the burst: WREADY drops, go to RESP, BVALID=1 on the next cycle.
//   - AWLEN=0 is a single beat.
// - FSM RESP (BVALID=1): BVALID and BRESP are held until BREADY. On handshake go to IDLE; AWREADY=1 on the next cycle.
//   - If BREADY is already high, the handshake completes in the first BVALID cycle.
// - Only one burst is outstanding. AWREADY=0 outside IDLE.
// - Address generation (per beat, modulo 2^ADDR_W):
//   - FIXED: address is constant.
//   - INCR: +4 per beat.
//   - WRAP: +4 per beat, wrapping within a (AWLEN+1)*4 byte boundary aligned to that size.
//   - Word index = addr[ADDR_W-1:2]. addr[1:0] is ignored.
// - Errors set a sticky flag and make BRESP=SLVERR for the burst; the burst still runs to AWLEN+1 beats:
//   - AWSIZE!=2: no beats are written.
//   - AWBUSRT=11: treated as INCR.
//   - WRAP with AWLEN not in {1,3,7,15}: treated as INCR.
//   - Word index >= DEPTH: that beat is not written.
//   - WLAST=1 on any beat but the last, or WLAST=0 on the last beat.
// - WLAST never terminates a burst; only the beat count does.
// - Reset mid-burst aborts immediately:
//   - No B response is issued.
//   - Beats already written stay in memory.
// STRUCTURE
// - axi_pkg holds:
//   - burst_e (FIXED/INCR/WRAP/RSVD)
//   - resp_e (OKAY=2'b00, SLVERR=2'b10)
//   - wr_state_e (IDLE/DATA/RESP)
//   - BEAT_BYTES=4
// - Sub-module axi_burst_addr: combinational next-address from cur_addr, AWLEN and AWBUSRT, plus a wrap-legal flag.
// - Memory is an inferred reg array with a synchronous write and a registered debug read.
// TESTING
// - INCR: AWADDR=0x0010, AWLEN=3, AWSIZE=2, data A0..A3 -> mem[4..7]=A0..A3, BRESP=00, one BVALID pulse.
// - WRAP: AWADDR=0x0018, AWLEN=3, data B0..B3 -> mem[6]=B0, mem[7]=B1, mem[4]=B2, mem[5]=B3, BRESP=00.
// - FIXED: AWADDR=0x0020, AWLEN=2, data C0..C2 -> mem[8]=C2 only, BRESP=00.
// - Errors:
//   - AWADDR=0x0400 (index 256) -> nothing written, BRESP=10.
//   - AWSIZE=1 -> nothing written, BRESP=10.
//   - AWLEN=3 with WLAST on beat 1 -> 4 beats written, BRESP=10.
// - Handshake: BREADY held low for 5 cycles -> BVALID/BRESP stable, AWREADY=0; W presented before AW -> WREADY stays 0 until the cycle after the AW handshake.
// - Reset: RESET low after beat 2 of an AWLEN=7 burst -> outputs are at reset values, no BVALID; after release, AWREADY=1 and the next burst completes normally.

Source files
------------

// File: rtl/axi_wr_slave_pkg.sv
// Shared types and constants for the AXI write-channel responder.
package axi_pkg;

   localparam int BEAT_BYTES = 4;

   typedef enum logic [1:0] {
      FIXED = 2'b00,
      INCR  = 2'b01,
      WRAP  = 2'b10,
      RSVD  = 2'b11
   } burst_e;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } resp_e;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      RESP
   } wr_state_e;

   // A wrapping burst must cover 2, 4, 8 or 16 beats.
   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/axi_wr_slave_if.sv
// AW, W and B channel signals of the write bus, seen from either side.
interface axi_wr_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) ();

   logic [ADDR_W-1:0] awaddr;
   logic [7:0]        awlen;
   logic [2:0]        awsize;
   logic [1:0]        awbusrt;
   logic              awvalid;
   logic              awready;
   logic [DATA_W-1:0] wdata;
   logic              wlast;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;

   modport master (
      output awaddr, awlen, awsize, awbusrt, awvalid,
      input  awready,
      output wdata, wlast, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready
   );

   modport slave (
      input  awaddr, awlen, awsize, awbusrt, awvalid,
      output awready,
      input  wdata, wlast, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready
   );

endinterface

// File: rtl/axi_wr_slave_burst_addr.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
// Reserved bursts and wraps of an unsupported length step like INCR.
module axi_burst_addr
   import axi_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic [ADDR_W-1:0] cur_addr,
   input  logic [7:0]        len,
   input  logic [1:0]        burst,
   output logic [ADDR_W-1:0] next_addr,
   output logic              wrap_legal
);

   logic [ADDR_W-1:0] incr_addr;
   logic [ADDR_W-1:0] wrap_mask;

   // For a legal wrap, (len+1)*4-1 is simply {len, 2'b11}, so the mask selects
   // the offset within the aligned wrap window and the upper bits stay put.
   always_comb begin
      wrap_legal = wrap_len_ok(len);
      incr_addr  = cur_addr + ADDR_W'(BEAT_BYTES);
      wrap_mask  = ADDR_W'({len, 2'b11});
      next_addr  = incr_addr;
      if (burst == FIXED) begin
         next_addr = cur_addr;
      end else if ((burst == WRAP) && wrap_legal) begin
         next_addr = (cur_addr & ~wrap_mask) | (incr_addr & wrap_mask);
      end
   end

endmodule

// File: rtl/axi_wr_slave.sv
// AXI write-channel responder: accepts one burst at a time, stores its beats in
// a word memory, and answers with a single B response per burst.
module axi_wr_slave
   import axi_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   axi_wr_if.slave           bus,
   input  logic [IDX_W-1:0]  dbg_raddr,
   output logic [DATA_W-1:0] dbg_rdata
);

   wr_state_e         state_q, state_d;
   logic              awready_q, awready_d;
   logic              wready_q, wready_d;
   logic              bvalid_q, bvalid_d;
   resp_e             bresp_q, bresp_d;

   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W-1:0] next_addr;
   logic [7:0]        len_q;
   logic [7:0]        beat_cnt;
   logic [1:0]        burst_q;
   logic              size_ok_q;
   logic              err_q;

   logic              aw_fire;
   logic              w_fire;
   logic              is_last;
   logic              in_range;
   logic              beat_err;
   logic              aw_err;
   logic              mem_we;
   logic              wrap_legal;
   logic [ADDR_W-3:0] word_idx;

   logic [DATA_W-1:0] mem [DEPTH];

   axi_burst_addr #(
      .ADDR_W (ADDR_W)
   ) u_burst_addr (
      .cur_addr   (cur_addr),
      .len        (len_q),
      .burst      (burst_q),
      .next_addr  (next_addr),
      .wrap_legal (wrap_legal)
   );

   // Handshakes, per-beat decode and the error sources of the current beat.
   always_comb begin
      aw_fire  = bus.awvalid & awready_q;
      w_fire   = bus.wvalid & wready_q;
      is_last  = (beat_cnt == len_q);
      word_idx = cur_addr[ADDR_W-1:2];
      in_range = (32'(word_idx) < 32'(DEPTH));
      beat_err = (bus.wlast != is_last) | ~in_range;
      mem_we   = w_fire & size_ok_q & in_range;
      aw_err   = (bus.awsize != 3'd2) | (bus.awbusrt == RSVD) |
                 ((bus.awbusrt == WRAP) & ~wrap_len_ok(bus.awlen));
   end

   // Next state and next values of the registered handshake outputs.
   always_comb begin
      state_d   = state_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      case (state_q)
         IDLE: begin
            awready_d = 1'b1;
            if (aw_fire) begin
               state_d   = DATA;
               awready_d = 1'b0;
               wready_d  = 1'b1;
            end
         end
         DATA: begin
            if (w_fire && is_last) begin
               state_d  = RESP;
               wready_d = 1'b0;
               bvalid_d = 1'b1;
               bresp_d  = (err_q || beat_err) ? SLVERR : OKAY;
            end
         end
         RESP: begin
            if (bvalid_q && bus.bready) begin
               state_d   = IDLE;
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
            end
         end
         default: begin
            state_d   = IDLE;
            awready_d = 1'b0;
            wready_d  = 1'b0;
            bvalid_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any burst without a response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= OKAY;
      end else begin
         state_q   <= state_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
      end
   end

   // Burst context: latched on the AW handshake, advanced on every W beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_addr  <= '0;
         len_q     <= '0;
         burst_q   <= '0;
         size_ok_q <= 1'b0;
         err_q     <= 1'b0;
         beat_cnt  <= '0;
      end else if (aw_fire) begin
         cur_addr  <= bus.awaddr;
         len_q     <= bus.awlen;
         burst_q   <= bus.awbusrt;
         size_ok_q <= (bus.awsize == 3'd2);
         err_q     <= aw_err;
         beat_cnt  <= '0;
      end else if (w_fire) begin
         cur_addr <= next_addr;
         beat_cnt <= beat_cnt + 8'd1;
         if (beat_err) begin
            err_q <= 1'b1;
         end
      end
   end

   // Word memory write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[word_idx[IDX_W-1:0]] <= bus.wdata;
      end
   end

   // Registered debug read port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dbg_rdata <= '0;
      end else begin
         dbg_rdata <= mem[dbg_raddr];
      end
   end

   assign bus.awready = awready_q;
   assign bus.wready  = wready_q;
   assign bus.bvalid  = bvalid_q;
   assign bus.bresp   = bresp_q;

endmodule

// File: tb/tb_axi_wr_slave.sv
// Self-checking bench for axi_wr_slave: directed bursts followed by random
// bursts, checked against a beat-by-beat address/memory/response model.
module tb_axi_wr_slave;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 256;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [7:0]        dbgRaddr;
   logic [DATA_W-1:0] dbgRdata;

   int checks = 0;
   int errors = 0;

   logic [31:0] modelMem   [DEPTH];
   bit          modelKnown [DEPTH];
   int          touched[$];

   axi_wr_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   axi_wr_slave #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .dbg_raddr (dbgRaddr),
      .dbg_rdata (dbgRdata)
   );

   always #5 clk = ~clk;

   function automatic bit wrapOk(input int len);
      return (len == 1) || (len == 3) || (len == 7) || (len == 15);
   endfunction

   // Byte address of beat i, straight from the burst-type rules.
   function automatic int beatAddr(input int addr, input int len, input int btype, input int i);
      int size;
      int base;
      int a;
      if (btype == 0) begin
         a = addr;
      end else if (btype == 2 && wrapOk(len)) begin
         size = (len + 1) * 4;
         base = addr - (addr % size);
         a    = base + ((addr - base) + 4 * i) % size;
      end else begin
         a = addr + 4 * i;
      end
      return a % 65536;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkMem(input int idx);
      @(negedge clk);
      dbgRaddr = 8'(idx);
      @(negedge clk);
      checkOutput($sformatf("mem[%0d]", idx), dbgRdata, modelMem[idx]);
   endtask

   task automatic sweepMem();
      for (int i = 0; i < DEPTH; i++) begin
         if (modelKnown[i]) checkMem(i);
      end
   endtask

   task automatic driveAw(input int addr, input int len, input int size, input int burst);
      int cnt = 0;
      @(negedge clk);
      bus.awaddr  = 16'(addr);
      bus.awlen   = 8'(len);
      bus.awsize  = 3'(size);
      bus.awbusrt = 2'(burst);
      bus.awvalid = 1'b1;
      while (bus.awready !== 1'b1 && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      checkOutput("awready_wait", 32'(bus.awready), 32'd1);
      @(posedge clk);
      #1 bus.awvalid = 1'b0;
   endtask

   task automatic driveBeat(input logic [31:0] data, input bit last, input bit allowGap, input bit expectReady);
      int cnt = 0;
      if (allowGap && $urandom_range(0, 3) == 0) @(negedge clk);
      @(negedge clk);
      bus.wdata  = data;
      bus.wlast  = last;
      bus.wvalid = 1'b1;
      if (expectReady) checkOutput("wready_after_aw", 32'(bus.wready), 32'd1);
      while (bus.wready !== 1'b1 && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      checkOutput("wready_wait", 32'(bus.wready), 32'd1);
      @(posedge clk);
      #1;
      bus.wvalid = 1'b0;
      bus.wlast  = 1'b0;
   endtask

   // One full burst: model update, AW, W beats, B response, memory readback.
   task automatic applyStimulus(input int addr, input int len, input int size, input int burst,
                                input int badBeat, input int hold, input bit earlyReady, input bit wFirst);
      logic [31:0] data[$];
      bit          lasts[$];
      bit          err;
      int          a;
      int          idx;
      int          cnt;
      logic [1:0]  expResp;
      touched.delete();
      err = (size != 2) || (burst == 3) || (burst == 2 && !wrapOk(len));
      for (int i = 0; i <= len; i++) begin
         a   = beatAddr(addr, len, burst, i);
         idx = a / 4;
         data.push_back($urandom);
         lasts.push_back((i == len) != (i == badBeat));
         if (i == badBeat) err = 1'b1;
         if (idx >= DEPTH) begin
            err = 1'b1;
         end else if (size == 2) begin
            modelMem[idx]   = data[i];
            modelKnown[idx] = 1'b1;
            touched.push_back(idx);
         end
      end
      expResp = err ? 2'b10 : 2'b00;
      if (earlyReady) bus.bready = 1'b1;
      if (wFirst) begin
         @(negedge clk);
         bus.wdata  = data[0];
         bus.wlast  = lasts[0];
         bus.wvalid = 1'b1;
         repeat (3) begin
            @(negedge clk);
            checkOutput("wready_before_aw", 32'(bus.wready), 32'd0);
         end
      end
      driveAw(addr, len, size, burst);
      for (int i = 0; i <= len; i++) begin
         driveBeat(data[i], lasts[i], !(wFirst && i == 0), wFirst && i == 0);
      end
      cnt = 0;
      @(negedge clk);
      while (bus.bvalid !== 1'b1 && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      checkOutput("bvalid_wait", 32'(bus.bvalid), 32'd1);
      checkOutput("wready_low_in_resp", 32'(bus.wready), 32'd0);
      for (int k = 0; k < hold; k++) begin
         checkOutput("bvalid_hold", 32'(bus.bvalid), 32'd1);
         checkOutput("bresp_hold", 32'(bus.bresp), 32'(expResp));
         checkOutput("awready_in_resp", 32'(bus.awready), 32'd0);
         @(negedge clk);
      end
      bus.bready = 1'b1;
      checkOutput("bresp", 32'(bus.bresp), 32'(expResp));
      @(posedge clk);
      @(negedge clk);
      bus.bready = 1'b0;
      checkOutput("bvalid_single_pulse", 32'(bus.bvalid), 32'd0);
      checkOutput("awready_after_b", 32'(bus.awready), 32'd1);
      foreach (touched[j]) checkMem(touched[j]);
   endtask

   initial begin
      logic [31:0] d0;
      logic [31:0] d1;
      int          rAddr;
      int          rLen;
      int          rSize;
      int          rBurst;
      int          rBad;
      int          rHold;
      bit          rEarly;
      bit          rWFirst;

      rst_n       = 1'b0;
      bus.awaddr  = '0;
      bus.awlen   = '0;
      bus.awsize  = '0;
      bus.awbusrt = '0;
      bus.awvalid = 1'b0;
      bus.wdata   = '0;
      bus.wlast   = 1'b0;
      bus.wvalid  = 1'b0;
      bus.bready  = 1'b0;
      dbgRaddr    = '0;

      // Reset values, then AWREADY on the first edge after release.
      repeat (3) @(negedge clk);
      checkOutput("rst_awready", 32'(bus.awready), 32'd0);
      checkOutput("rst_wready", 32'(bus.wready), 32'd0);
      checkOutput("rst_bvalid", 32'(bus.bvalid), 32'd0);
      checkOutput("rst_bresp", 32'(bus.bresp), 32'd0);
      checkOutput("rst_dbg_rdata", dbgRdata, 32'd0);
      rst_n = 1'b1;
      #1 checkOutput("awready_before_edge", 32'(bus.awready), 32'd0);
      @(negedge clk);
      checkOutput("awready_after_release", 32'(bus.awready), 32'd1);

      // Preload regions that later error bursts must leave alone.
      applyStimulus(16'h0000, 15, 2, 1, -1, 0, 1'b0, 1'b0);
      applyStimulus(16'h0100, 7, 2, 1, -1, 0, 1'b0, 1'b0);

      // INCR, WRAP and FIXED bursts.
      applyStimulus(16'h0010, 3, 2, 1, -1, 1, 1'b0, 1'b0);
      applyStimulus(16'h0018, 3, 2, 2, -1, 1, 1'b0, 1'b0);
      applyStimulus(16'h0020, 2, 2, 0, -1, 1, 1'b0, 1'b0);

      // Error bursts.
      applyStimulus(16'h0400, 3, 2, 1, -1, 0, 1'b0, 1'b0);
      applyStimulus(16'h0010, 3, 1, 1, -1, 0, 1'b0, 1'b0);
      sweepMem();
      applyStimulus(16'h0030, 3, 2, 1, 1, 0, 1'b0, 1'b0);
      applyStimulus(16'h0040, 2, 2, 2, -1, 0, 1'b0, 1'b0);
      applyStimulus(16'h0050, 1, 2, 3, -1, 0, 1'b0, 1'b0);
      applyStimulus(16'h03F8, 3, 2, 1, -1, 0, 1'b0, 1'b0);

      // Handshake corner cases.
      applyStimulus(16'h0060, 1, 2, 1, -1, 5, 1'b0, 1'b0);
      applyStimulus(16'h0070, 0, 2, 1, -1, 0, 1'b1, 1'b0);
      applyStimulus(16'h0080, 2, 2, 1, -1, 1, 1'b0, 1'b1);

      // Reset after two beats of an eight-beat burst.
      d0 = $urandom;
      d1 = $urandom;
      modelMem[64] = d0;
      modelMem[65] = d1;
      driveAw(16'h0100, 7, 2, 1);
      driveBeat(d0, 1'b0, 1'b0, 1'b0);
      driveBeat(d1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_awready", 32'(bus.awready), 32'd0);
      checkOutput("mid_rst_wready", 32'(bus.wready), 32'd0);
      checkOutput("mid_rst_bvalid", 32'(bus.bvalid), 32'd0);
      checkOutput("mid_rst_bresp", 32'(bus.bresp), 32'd0);
      checkOutput("mid_rst_dbg_rdata", dbgRdata, 32'd0);
      repeat (3) begin
         @(negedge clk);
         checkOutput("bvalid_in_reset", 32'(bus.bvalid), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("awready_after_mid_rst", 32'(bus.awready), 32'd1);
      checkOutput("bvalid_after_mid_rst", 32'(bus.bvalid), 32'd0);
      for (int i = 64; i < 72; i++) checkMem(i);
      applyStimulus(16'h0104, 7, 2, 1, -1, 2, 1'b0, 1'b0);

      // Random bursts.
      for (int r = 0; r < 40; r++) begin
         rAddr   = int'($urandom_range(0, 16'h0440));
         rLen    = int'($urandom_range(0, 15));
         rSize   = ($urandom_range(0, 9) == 0) ? 1 : 2;
         rBurst  = int'($urandom_range(0, 3));
         rBad    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, rLen)) : -1;
         rHold   = int'($urandom_range(0, 3));
         rEarly  = (rHold == 0) && ($urandom_range(0, 1) == 1);
         rWFirst = ($urandom_range(0, 7) == 0);
         applyStimulus(rAddr, rLen, rSize, rBurst, rBad, rHold, rEarly, rWFirst);
      end
      sweepMem();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
